// File: rtl/mem_pkg.sv
// Shared types and widths for the memory copy/fill engine.
// The op and state encodings are shared with anything that interprets them.
package mem_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic {
      OP_COPY = 1'b0,
      OP_FILL = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   function automatic logic [ADDR_W-1:0] ptr_inc(
      input logic [ADDR_W-1:0] p,
      input int                depth
   );
      if (int'(p) >= depth - 1) return '0;
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/mem_copier.sv
// Byte-serial COPY/FILL engine driving a single-port data memory.
// COPY alternates RD/WR per byte; FILL streams WR cycles back to back.
module mem_copier
   import mem_pkg::*;
#(
   parameter int MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              op,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [7:0]        len,
   input  logic [DATA_W-1:0] fill_val,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done
);

   state_e            state_q;
   op_e               op_q;
   logic [ADDR_W-1:0] src_q, dst_q;
   logic [ADDR_W-1:0] src_d, dst_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] hold_q, fill_q;

   assign src_d = ptr_inc(src_q, MEM_DEPTH);
   assign dst_d = ptr_inc(dst_q, MEM_DEPTH);
   assign cnt_d = cnt_q - 8'd1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_COPY;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         fill_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q   <= op_e'(op);
                  src_q  <= src;
                  dst_q  <= dst;
                  cnt_q  <= len;
                  fill_q <= fill_val;
                  if (len == 8'd0)
                     state_q <= S_DONE;
                  else if (op_e'(op) == OP_FILL)
                     state_q <= S_WR;
                  else
                     state_q <= S_RD;
               end
            end
            S_RD: begin
               hold_q  <= mem_rdata;
               src_q   <= src_d;
               state_q <= S_WR;
            end
            S_WR: begin
               dst_q <= dst_d;
               cnt_q <= cnt_d;
               // FILL simply stays in WR until the count runs out
               if (cnt_d == 8'd0)
                  state_q <= S_DONE;
               else if (op_q == OP_COPY)
                  state_q <= S_RD;
            end
            S_DONE: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state_q == S_RD) || (state_q == S_WR);
   assign done      = (state_q == S_DONE);
   assign mem_wr_en = (state_q == S_WR);
   assign mem_addr  = (state_q == S_RD) ? src_q : dst_q;
   assign mem_wdata = (op_q == OP_FILL) ? fill_q : hold_q;

endmodule

// File: tb/tb_mem_copier.sv
// Self-checking bench: random memory image, reference model of COPY/FILL
// semantics, cycle-exact done timing and reset-abort behaviour.
module tb_mem_copier;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       op = 1'b0;
   logic [7:0] src = '0, dst = '0, len = '0, fill_val = '0;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_wr_en, busy, done;

   logic [7:0] mem  [256];
   logic [7:0] refm [256];

   int vectors = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mem_copier #(.MEM_DEPTH(256)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .src(src), .dst(dst), .len(len), .fill_val(fill_val),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .done(done)
   );

   // dat_mem: combinational read, write on rising edge
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_wr_en) mem[mem_addr] = mem_wdata;

   task automatic poke(input logic [7:0] a, input logic [7:0] v);
      mem[a] = v;
      refm[a] = v;
   endtask

   function automatic int first_diff();
      for (int i = 0; i < 256; i++)
         if (mem[i] !== refm[i]) return i;
      return -1;
   endfunction

   task automatic ref_copy(input logic [7:0] s, input logic [7:0] d,
                           input int n);
      for (int i = 0; i < n; i++)
         refm[8'(d + i)] = refm[8'(s + i)];
   endtask

   task automatic ref_fill(input logic [7:0] d, input int n,
                           input logic [7:0] v);
      for (int i = 0; i < n; i++) refm[8'(d + i)] = v;
   endtask

   // Issue a command; cycle c=1 is the cycle after the start edge.
   // inject>0 raises a conflicting start during cycle `inject`.
   task automatic run_cmd(input logic o, input logic [7:0] s,
                          input logic [7:0] d, input logic [7:0] n,
                          input logic [7:0] fv, input int inject,
                          output int done_c, output int busy_c,
                          output int wr_c);
      done_c = -1; busy_c = 0; wr_c = 0;
      @(negedge clk);
      start = 1'b1; op = o; src = s; dst = d; len = n; fill_val = fv;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk);
         if (busy) busy_c++;
         if (mem_wr_en) wr_c++;
         if (c == inject) begin
            start = 1'b1; op = ~o; src = ~s; dst = ~d;
            len = 8'd2; fill_val = ~fv;
         end else if (c == inject + 1) begin
            start = 1'b0;
         end
         if (done) begin
            done_c = c;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({mem_wr_en, busy, done} !== 3'b000) begin
         errs++;
         $display("FAIL reset_ctl got %b want 000", {mem_wr_en, busy, done});
      end
      vectors++;
      if (mem_addr !== 8'h00) begin
         errs++;
         $display("FAIL reset_addr got %h want 00", mem_addr);
      end
      vectors++;
      if (mem_wdata !== 8'h00) begin
         errs++;
         $display("FAIL reset_wdata got %h want 00", mem_wdata);
      end
      #1 reset_n = 1'b1;
   endtask

   task automatic test_copy_basic();
      int dc, bc, wc, fd;
      logic [7:0] pat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), pat[i]);
      run_cmd(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 0, dc, bc, wc);
      ref_copy(8'h10, 8'h80, 4);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (mem[8'h80 + i] !== pat[i]) begin
            errs++;
            $display("FAIL copy_byte%0d got %h want %h", i,
                     mem[8'h80 + i], pat[i]);
         end
      end
      vectors++;
      if (dc !== 9) begin
         errs++;
         $display("FAIL copy_done_cycle got %0d want 9", dc);
      end
      vectors++;
      if (bc !== 8) begin
         errs++;
         $display("FAIL copy_busy_cycles got %0d want 8", bc);
      end
      fd = first_diff();
      vectors++;
      if (fd != -1) begin
         errs++;
         $display("FAIL copy_mem addr %0d got %h want %h", fd, mem[fd],
                  refm[fd]);
      end
   endtask

   task automatic test_fill_wrap();
      int dc, bc, wc, fd;
      logic [7:0] keep;
      keep = mem[8'h01];
      run_cmd(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, 0, dc, bc, wc);
      ref_fill(8'hFE, 3, 8'h5A);
      vectors++;
      if ({mem[8'hFE], mem[8'hFF], mem[8'h00]} !== 24'h5A5A5A) begin
         errs++;
         $display("FAIL fill_wrap got %h %h %h want 5a x3", mem[8'hFE],
                  mem[8'hFF], mem[8'h00]);
      end
      vectors++;
      if (mem[8'h01] !== keep) begin
         errs++;
         $display("FAIL fill_untouched got %h want %h", mem[8'h01], keep);
      end
      vectors++;
      if (dc !== 4) begin
         errs++;
         $display("FAIL fill_done_cycle got %0d want 4", dc);
      end
      fd = first_diff();
      vectors++;
      if (fd != -1) begin
         errs++;
         $display("FAIL fill_mem addr %0d got %h want %h", fd, mem[fd],
                  refm[fd]);
      end
   endtask

   task automatic test_len0();
      int dc, bc, wc, fd;
      run_cmd(1'b0, 8'h33, 8'h44, 8'd0, 8'h00, 0, dc, bc, wc);
      vectors++;
      if (wc !== 0) begin
         errs++;
         $display("FAIL len0_writes got %0d want 0", wc);
      end
      vectors++;
      if (dc !== 1) begin
         errs++;
         $display("FAIL len0_done_cycle got %0d want 1", dc);
      end
      fd = first_diff();
      vectors++;
      if (fd != -1) begin
         errs++;
         $display("FAIL len0_mem addr %0d got %h want %h", fd, mem[fd],
                  refm[fd]);
      end
   endtask

   task automatic test_overlap();
      int dc, bc, wc;
      poke(8'h20, 8'h77);
      run_cmd(1'b0, 8'h20, 8'h21, 8'd3, 8'h00, 0, dc, bc, wc);
      ref_copy(8'h20, 8'h21, 3);
      for (int i = 1; i <= 3; i++) begin
         vectors++;
         if (mem[8'h20 + i] !== 8'h77) begin
            errs++;
            $display("FAIL overlap_byte%0d got %h want 77", i,
                     mem[8'h20 + i]);
         end
      end
   endtask

   task automatic test_start_ignored();
      int dc, bc, wc, fd;
      for (int i = 0; i < 4; i++) poke(8'(8'h50 + i), 8'($urandom));
      run_cmd(1'b0, 8'h50, 8'h60, 8'd4, 8'h00, 3, dc, bc, wc);
      ref_copy(8'h50, 8'h60, 4);
      vectors++;
      if (dc !== 9) begin
         errs++;
         $display("FAIL ignore_done_cycle got %0d want 9", dc);
      end
      vectors++;
      if (wc !== 4) begin
         errs++;
         $display("FAIL ignore_writes got %0d want 4", wc);
      end
      fd = first_diff();
      vectors++;
      if (fd != -1) begin
         errs++;
         $display("FAIL ignore_mem addr %0d got %h want %h", fd, mem[fd],
                  refm[fd]);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errs++;
         $display("FAIL ignore_idle got busy=%b done=%b want 0 0", busy,
                  done);
      end
   endtask

   task automatic test_reset_mid();
      int late_done, late_wr, fd;
      for (int i = 0; i < 8; i++) poke(8'(8'h90 + i), 8'($urandom));
      @(negedge clk);
      start = 1'b1; op = 1'b0; src = 8'h90; dst = 8'hC0; len = 8'd8;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 8'hC1) begin
         errs++;
         $display("FAIL abort_pre got wr=%b addr=%h want 1 c1", mem_wr_en,
                  mem_addr);
      end
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      ref_copy(8'h90, 8'hC0, 2);
      @(negedge clk);
      vectors++;
      if ({mem_wr_en, busy, done} !== 3'b000) begin
         errs++;
         $display("FAIL abort_post got %b want 000",
                  {mem_wr_en, busy, done});
      end
      late_done = 0; late_wr = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) late_done++;
         if (mem_wr_en) late_wr++;
      end
      vectors++;
      if (late_done !== 0 || late_wr !== 0) begin
         errs++;
         $display("FAIL abort_quiet got done=%0d wr=%0d want 0 0",
                  late_done, late_wr);
      end
      fd = first_diff();
      vectors++;
      if (fd != -1) begin
         errs++;
         $display("FAIL abort_mem addr %0d got %h want %h", fd, mem[fd],
                  refm[fd]);
      end
   endtask

   task automatic test_random();
      int dc, bc, wc, fd, n, want;
      logic o;
      logic [7:0] s, d, v;
      for (int t = 0; t < 24; t++) begin
         o = 1'($urandom);
         s = 8'($urandom);
         d = 8'($urandom);
         v = 8'($urandom);
         n = (t % 6 == 5) ? 0 : $urandom_range(1, 24);
         run_cmd(o, s, d, 8'(n), v, 0, dc, bc, wc);
         if (o) ref_fill(d, n, v);
         else ref_copy(s, d, n);
         want = (n == 0) ? 1 : (o ? n + 1 : 2 * n + 1);
         vectors++;
         if (dc !== want || wc !== n) begin
            errs++;
            $display("FAIL rand%0d timing got done=%0d wr=%0d want %0d %0d",
                     t, dc, wc, want, n);
         end
         fd = first_diff();
         vectors++;
         if (fd != -1) begin
            errs++;
            $display("FAIL rand%0d mem addr %0d got %h want %h", t, fd,
                     mem[fd], refm[fd]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
      test_reset();
      test_copy_basic();
      test_fill_wrap();
      test_len0();
      test_overlap();
      test_start_ignored();
      test_reset_mid();
      test_copy_basic();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
